// File: rtl/cpu_program_memory_pkg.sv
// Shared definitions for the CPU program memory and its byte-serial loader.
// Holds program address/data widths, the fetch NOP word, the loader state
// encoding and small helpers that build an instruction word from two bytes.
// Optional feature macro used by the top level: PROGRAM_LOAD_CHECKSUM_EN.
package cpu_program_memory_pkg;

    localparam int unsigned PROG_ADDR_WIDTH = 9;
    localparam int unsigned PROG_DATA_WIDTH = 12;  // legal range 9..16
    localparam int unsigned PROG_DEPTH      = 2 ** PROG_ADDR_WIDTH;

    localparam logic [PROG_DATA_WIDTH-1:0] CPU_NOP = '0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitLo = 2'd1,
        StWaitHi = 2'd2
    } load_state_e;

    // Instruction word from the high and low loader bytes; surplus high bits dropped.
    function automatic logic [PROG_DATA_WIDTH-1:0] pack_word(input logic [7:0] hi,
                                                             input logic [7:0] lo);
        logic [15:0] full;
        full = {hi, lo};
        return full[PROG_DATA_WIDTH-1:0];
    endfunction

    // True when the high byte carries bits that do not fit in the instruction word.
    function automatic logic hi_bits_bad(input logic [7:0] hi);
        logic [15:0] full;
        full = {hi, 8'h00};
        return |(full >> PROG_DATA_WIDTH);
    endfunction

endpackage

// File: rtl/cpu_program_ram.sv
// Single-port program RAM: synchronous write, registered read.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   addr   in  word address (shared by read and write)
//   wdata  in  write data
//   rdata  out registered read data, rdata(t+1) = mem[addr(t)]
// Contents are not reset.
module cpu_program_ram #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cpu_program_memory.sv
// Program-side responder for the CPU instruction fetch path with a
// byte-serial image loader. Words arrive as low byte then high byte and are
// written to on-chip RAM from address 0; the CPU is held while loading.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc_to_program_rom   fetch address from the PC
//   program_bus         fetched instruction, one cycle latency, NOP while held
//   load_start/load_end begin (restart) / finish an image load
//   load_data/valid     loader byte stream, load_ready is the accept handshake
//   cpu_hold            high while loading
//   load_error          sticky malformed-image flag, cleared by load_start
//   words_loaded        words written in the current/last load (saturating)
//   load_checksum       mod-256 sum of accepted bytes, only when
//                       PROGRAM_LOAD_CHECKSUM_EN is defined
module cpu_program_memory
    import cpu_program_memory_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PROG_ADDR_WIDTH-1:0] pc_to_program_rom,
    output logic [PROG_DATA_WIDTH-1:0] program_bus,
    input  logic                       load_start,
    input  logic                       load_end,
    input  logic [7:0]                 load_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic                       cpu_hold,
    output logic                       load_error,
    output logic [PROG_ADDR_WIDTH:0]   words_loaded
`ifdef PROGRAM_LOAD_CHECKSUM_EN
    ,
    output logic [7:0]                 load_checksum
`endif
);

    localparam logic [PROG_ADDR_WIDTH-1:0] LAST_ADDR = PROG_ADDR_WIDTH'(PROG_DEPTH - 1);
    localparam logic [PROG_ADDR_WIDTH:0]   WORDS_MAX = (PROG_ADDR_WIDTH + 1)'(PROG_DEPTH);

    load_state_e                state;
    logic [PROG_ADDR_WIDTH-1:0] load_addr;
    logic [7:0]                 lo_byte;
    logic                       nop_gate;
    logic                       transfer;
    logic                       ram_we;
    logic [PROG_ADDR_WIDTH-1:0] ram_addr;
    logic [PROG_DATA_WIDTH-1:0] ram_wdata;
    logic [PROG_DATA_WIDTH-1:0] ram_rdata;

    // load_end wins over a byte presented in the same cycle.
    assign load_ready = ((state == StWaitLo) || (state == StWaitHi)) && !load_end;
    assign transfer   = load_valid && load_ready;

    // load_start has priority over the write of a completing word.
    assign ram_we    = (state == StWaitHi) && transfer && !load_start;
    assign ram_wdata = pack_word(load_data, lo_byte);
    assign ram_addr  = cpu_hold ? load_addr : pc_to_program_rom;

    cpu_program_ram #(
        .ADDR_WIDTH (PROG_ADDR_WIDTH),
        .DATA_WIDTH (PROG_DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Loader FSM; cpu_hold tracks the state so it is high exactly in WAIT_LO/WAIT_HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            cpu_hold      <= 1'b0;
            load_addr     <= '0;
            lo_byte       <= 8'h00;
            load_error    <= 1'b0;
            words_loaded  <= '0;
`ifdef PROGRAM_LOAD_CHECKSUM_EN
            load_checksum <= 8'h00;
`endif
        end else if (load_start) begin
            state         <= StWaitLo;
            cpu_hold      <= 1'b1;
            load_addr     <= '0;
            load_error    <= 1'b0;
            words_loaded  <= '0;
`ifdef PROGRAM_LOAD_CHECKSUM_EN
            load_checksum <= 8'h00;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    cpu_hold <= 1'b0;
                end
                StWaitLo: begin
                    if (load_end) begin
                        state    <= StIdle;
                        cpu_hold <= 1'b0;
                    end else if (transfer) begin
                        lo_byte <= load_data;
                        state   <= StWaitHi;
`ifdef PROGRAM_LOAD_CHECKSUM_EN
                        load_checksum <= load_checksum + load_data;
`endif
                    end
                end
                StWaitHi: begin
                    if (load_end) begin
                        // Half a word pending: the image is truncated.
                        load_error <= 1'b1;
                        state      <= StIdle;
                        cpu_hold   <= 1'b0;
                    end else if (transfer) begin
                        load_addr <= load_addr + 1'b1;
                        if (words_loaded != WORDS_MAX) begin
                            words_loaded <= words_loaded + 1'b1;
                        end
                        if (hi_bits_bad(load_data)) begin
                            load_error <= 1'b1;
                        end
`ifdef PROGRAM_LOAD_CHECKSUM_EN
                        load_checksum <= load_checksum + load_data;
`endif
                        if (load_addr == LAST_ADDR) begin
                            state    <= StIdle;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= StWaitLo;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

    // The RAM read port serves the loader while held, so the first word after
    // release is also a NOP; reset forces NOP until the first fetch completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nop_gate <= 1'b1;
        end else begin
            nop_gate <= cpu_hold;
        end
    end

    always_comb begin
        program_bus = ram_rdata;
        if (cpu_hold || nop_gate) begin
            program_bus = CPU_NOP;
        end
    end

endmodule

// File: tb/tb_cpu_program_memory.sv
module tb_cpu_program_memory;
    import cpu_program_memory_pkg::*;

    localparam int AW    = PROG_ADDR_WIDTH;
    localparam int DW    = PROG_DATA_WIDTH;
    localparam int DEPTH = PROG_DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc_to_program_rom = '0;
    logic [DW-1:0] program_bus;
    logic          load_start = 1'b0;
    logic          load_end = 1'b0;
    logic [7:0]    load_data = 8'h00;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          cpu_hold;
    logic          load_error;
    logic [AW:0]   words_loaded;
`ifdef PROGRAM_LOAD_CHECKSUM_EN
    logic [7:0]    load_checksum;
`endif

    always #5 clk = ~clk;

    cpu_program_memory dut (
        .clk               (clk),
        .rst               (rst),
        .pc_to_program_rom (pc_to_program_rom),
        .program_bus       (program_bus),
        .load_start        (load_start),
        .load_end          (load_end),
        .load_data         (load_data),
        .load_valid        (load_valid),
        .load_ready        (load_ready),
        .cpu_hold          (cpu_hold),
        .load_error        (load_error),
        .words_loaded      (words_loaded)
`ifdef PROGRAM_LOAD_CHECKSUM_EN
        ,
        .load_checksum     (load_checksum)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: image load as a byte stream folded into words.
    bit         m_loading;
    int         m_widx;
    int         m_count;
    bit         m_err;
    int         m_csum;
    logic [7:0] m_lo_q[$];
    int         m_mem[DEPTH];
    bit         m_known[DEPTH];

    task automatic model_step(input bit st, input bit en, input bit v, input logic [7:0] d);
        int word;
        if (st) begin
            m_loading = 1;
            m_widx    = 0;
            m_count   = 0;
            m_err     = 0;
            m_csum    = 0;
            m_lo_q.delete();
        end else if (m_loading) begin
            if (en) begin
                if (m_lo_q.size() > 0) m_err = 1;
                m_lo_q.delete();
                m_loading = 0;
            end else if (v) begin
                m_csum = (m_csum + int'(d)) % 256;
                if (m_lo_q.size() == 0) begin
                    m_lo_q.push_back(d);
                end else begin
                    word = (int'(d) * 256 + int'(m_lo_q.pop_front())) % (1 << DW);
                    if (int'(d) >= (1 << (DW - 8))) m_err = 1;
                    m_mem[m_widx]   = word;
                    m_known[m_widx] = 1;
                    m_widx++;
                    if (m_count < DEPTH) m_count++;
                    if (m_widx == DEPTH) m_loading = 0;
                end
            end
        end
    endtask

    // One clock: drive inputs, check load_ready, clock, check registered outputs.
    task automatic cycle(input bit st, input bit en, input bit v, input logic [7:0] d,
                         input int pc);
        bit held_before;
        load_start        = st;
        load_end          = en;
        load_valid        = v;
        load_data         = d;
        pc_to_program_rom = AW'(pc);
        #1;
        check_val("load_ready", 32'(load_ready), 32'(m_loading && !en));
        held_before = m_loading;
        @(posedge clk);
        model_step(st, en, v, d);
        #1;
        check_val("cpu_hold", 32'(cpu_hold), 32'(m_loading));
        check_val("load_error", 32'(load_error), 32'(m_err));
        check_val("words_loaded", 32'(words_loaded), 32'(m_count));
`ifdef PROGRAM_LOAD_CHECKSUM_EN
        check_val("load_checksum", 32'(load_checksum), 32'(m_csum));
`endif
        if (m_loading || held_before) begin
            check_val("program_bus_nop", 32'(program_bus), 32'h0);
        end else if (m_known[pc]) begin
            check_val("program_bus", 32'(program_bus), 32'(m_mem[pc]));
        end
    endtask

    task automatic idle(input int pc);
        cycle(0, 0, 0, 8'h00, pc);
    endtask

    task automatic send(input logic [7:0] d);
        cycle(0, 0, 1, d, $urandom_range(DEPTH - 1));
    endtask

    task automatic do_reset();
        load_start = 0;
        load_end   = 0;
        load_valid = 0;
        rst        = 1;
        #2;
        check_val("rst_cpu_hold", 32'(cpu_hold), 32'h0);
        check_val("rst_load_error", 32'(load_error), 32'h0);
        check_val("rst_words", 32'(words_loaded), 32'h0);
        check_val("rst_ready", 32'(load_ready), 32'h0);
        check_val("rst_bus", 32'(program_bus), 32'h0);
`ifdef PROGRAM_LOAD_CHECKSUM_EN
        check_val("rst_checksum", 32'(load_checksum), 32'h0);
`endif
        m_loading = 0;
        m_count   = 0;
        m_err     = 0;
        m_csum    = 0;
        m_lo_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        logic [7:0] t2_bytes [6];
        logic [7:0] b;
        t2_bytes = '{8'h34, 8'h01, 8'hFF, 8'h0A, 8'h00, 8'h0C};
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

        do_reset();
        idle(5);

        // Three-word image.
        cycle(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) send(t2_bytes[i]);
        cycle(0, 1, 0, 8'h00, 0);
        check_val("t2_hold_fell", 32'(cpu_hold), 32'h0);
        check_val("t2_words", 32'(words_loaded), 32'd3);
        check_val("t2_error", 32'(load_error), 32'h0);
        idle(0);
        idle(0);
        check_val("t2_mem0", 32'(program_bus), 32'h134);
        idle(1);
        check_val("t2_mem1", 32'(program_bus), 32'hAFF);
        idle(2);
        check_val("t2_mem2", 32'(program_bus), 32'hC00);

        // Surplus high bits: word still written, error flagged and sticky.
        cycle(1, 0, 0, 8'h00, 0);
        send(8'h12);
        send(8'hF3);
        cycle(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) idle(0);
        check_val("t3_mem0", 32'(program_bus), 32'h312);
        check_val("t3_error_sticky", 32'(load_error), 32'h1);

        // Truncated word.
        cycle(1, 0, 0, 8'h00, 0);
        check_val("t4_error_cleared", 32'(load_error), 32'h0);
        send(8'h55);
        cycle(0, 1, 0, 8'h00, 0);
        check_val("t4_error", 32'(load_error), 32'h1);
        check_val("t4_words", 32'(words_loaded), 32'h0);
        idle(0);
        idle(0);
        check_val("t4_mem0_kept", 32'(program_bus), 32'h312);

        // Full image without load_end.
        cycle(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            b = 8'($urandom);
            if ((i % 2 == 1) && ($urandom_range(7) != 0)) b = b & 8'h0F;
            send(b);
        end
        check_val("t5_auto_idle", 32'(cpu_hold), 32'h0);
        check_val("t5_words", 32'(words_loaded), 32'(DEPTH));
        send(8'hA5);
        send(8'h5A);
        check_val("t5_words_after", 32'(words_loaded), 32'(DEPTH));
        for (int i = 0; i < 40; i++) idle($urandom_range(DEPTH - 1));

        // Reset in the middle of a load.
        cycle(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) send(8'($urandom) & 8'h0F);
        do_reset();
        idle(5);
        idle(5);
        check_val("t1_fetch5", 32'(program_bus), 32'(m_mem[5]));

        // Restart with stalls, then checksum of bytes 34,01.
        cycle(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, i % 2, 8'($urandom) & 8'h0F, 0);
        cycle(1, 0, 0, 8'h00, 0);
        check_val("t6_words_cleared", 32'(words_loaded), 32'h0);
        cycle(0, 0, 1, 8'h34, 0);
        cycle(0, 0, 0, 8'hEE, 0);
        cycle(0, 0, 1, 8'h01, 0);
`ifdef PROGRAM_LOAD_CHECKSUM_EN
        check_val("t6_checksum", 32'(load_checksum), 32'h35);
`endif
        cycle(0, 1, 1, 8'h77, 0);
        check_val("t6_words", 32'(words_loaded), 32'h1);
        idle(0);
        idle(0);
        check_val("t6_mem0", 32'(program_bus), 32'h134);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            b = 8'($urandom);
            if ($urandom_range(3) != 0) b = b & 8'h0F;
            cycle($urandom_range(99) < 2, $urandom_range(99) < 3, $urandom_range(99) < 60, b,
                  $urandom_range(DEPTH - 1));
        end
        cycle(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++) idle($urandom_range(DEPTH - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
